// File: rtl/xcfi_rvfi_emitter.sv
// In-order RVFI trace emitter: captures operands at issue, pairs them with retirement, drives one rvfi_* packet per retire.
// Optional memory tracing is enabled with `define XCFI_RVFI_MEM_TRACE_EN.
module xcfi_rvfi_emitter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [31:0]     iss_insn,
    input  logic [XLEN-1:0] iss_pc,
    input  logic [4:0]      iss_rs1_addr,
    input  logic [4:0]      iss_rs2_addr,
    input  logic [4:0]      iss_rs3_addr,
    input  logic [XLEN-1:0] iss_rs1_rdata,
    input  logic [XLEN-1:0] iss_rs2_rdata,
    input  logic [XLEN-1:0] iss_rs3_rdata,
    input  logic            ret_valid,
    input  logic            ret_trap,
    input  logic [4:0]      ret_rd_addr,
    input  logic [XLEN-1:0] ret_rd_wdata,
    input  logic [XLEN-1:0] ret_rd_wdatahi,
    input  logic            ret_rd_wide,
    input  logic [XLEN-1:0] ret_pc_wdata,
    input  logic [XLEN-1:0] ret_mem_addr,
    input  logic [3:0]      ret_mem_rmask,
    input  logic [3:0]      ret_mem_wmask,
    input  logic [XLEN-1:0] ret_mem_rdata,
    input  logic [XLEN-1:0] ret_mem_wdata,
    input  logic            flush,
    output logic            rvfi_valid,
    output logic [63:0]     rvfi_order,
    output logic [31:0]     rvfi_insn,
    output logic            rvfi_trap,
    output logic [XLEN-1:0] rvfi_pc_rdata,
    output logic [XLEN-1:0] rvfi_pc_wdata,
    output logic [4:0]      rvfi_rs1_addr,
    output logic [4:0]      rvfi_rs2_addr,
    output logic [4:0]      rvfi_rs3_addr,
    output logic [XLEN-1:0] rvfi_rs1_rdata,
    output logic [XLEN-1:0] rvfi_rs2_rdata,
    output logic [XLEN-1:0] rvfi_rs3_rdata,
    output logic [4:0]      rvfi_rd_addr,
    output logic [XLEN-1:0] rvfi_rd_wdata,
    output logic            rvfi_rd_wide,
    output logic [XLEN-1:0] rvfi_rd_wdatahi,
    output logic [XLEN-1:0] rvfi_mem_addr,
    output logic [3:0]      rvfi_mem_rmask,
    output logic [3:0]      rvfi_mem_wmask,
    output logic [XLEN-1:0] rvfi_mem_rdata,
    output logic [XLEN-1:0] rvfi_mem_wdata,
    output logic            err_underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [63:0]     next_order;

    logic [31:0]     q_insn      [DEPTH];
    logic [XLEN-1:0] q_pc        [DEPTH];
    logic [4:0]      q_rs1_addr  [DEPTH];
    logic [4:0]      q_rs2_addr  [DEPTH];
    logic [4:0]      q_rs3_addr  [DEPTH];
    logic [XLEN-1:0] q_rs1_rdata [DEPTH];
    logic [XLEN-1:0] q_rs2_rdata [DEPTH];
    logic [XLEN-1:0] q_rs3_rdata [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [4:0]    rd_addr_eff;
    logic          rd_is_x0;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty  = (wr_ptr == rd_ptr);
    assign pop    = ret_valid && !empty;
    // A pop frees a slot this cycle, so a full FIFO can still take an issue alongside a retire.
    assign iss_ready = !full || pop;
    assign push      = iss_valid && iss_ready && !flush;

    assign rd_addr_eff = ret_trap ? 5'd0 : ret_rd_addr;
    assign rd_is_x0    = (rd_addr_eff == 5'd0);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            if (ret_valid && empty)
                err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) begin
            q_insn[wr_idx]      <= iss_insn;
            q_pc[wr_idx]        <= iss_pc;
            q_rs1_addr[wr_idx]  <= iss_rs1_addr;
            q_rs2_addr[wr_idx]  <= iss_rs2_addr;
            q_rs3_addr[wr_idx]  <= iss_rs3_addr;
            q_rs1_rdata[wr_idx] <= iss_rs1_rdata;
            q_rs2_rdata[wr_idx] <= iss_rs2_rdata;
            q_rs3_rdata[wr_idx] <= iss_rs3_rdata;
        end
    end

    // Packet fields only change on a pop; otherwise they hold for the checkers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rvfi_valid      <= 1'b0;
            rvfi_order      <= '0;
            next_order      <= '0;
            rvfi_insn       <= '0;
            rvfi_trap       <= 1'b0;
            rvfi_pc_rdata   <= '0;
            rvfi_pc_wdata   <= '0;
            rvfi_rs1_addr   <= '0;
            rvfi_rs2_addr   <= '0;
            rvfi_rs3_addr   <= '0;
            rvfi_rs1_rdata  <= '0;
            rvfi_rs2_rdata  <= '0;
            rvfi_rs3_rdata  <= '0;
            rvfi_rd_addr    <= '0;
            rvfi_rd_wdata   <= '0;
            rvfi_rd_wide    <= 1'b0;
            rvfi_rd_wdatahi <= '0;
        end else begin
            rvfi_valid <= pop;
            if (pop) begin
                rvfi_order      <= next_order;
                next_order      <= next_order + 64'd1;
                rvfi_insn       <= q_insn[rd_idx];
                rvfi_trap       <= ret_trap;
                rvfi_pc_rdata   <= q_pc[rd_idx];
                rvfi_pc_wdata   <= ret_pc_wdata;
                rvfi_rs1_addr   <= q_rs1_addr[rd_idx];
                rvfi_rs2_addr   <= q_rs2_addr[rd_idx];
                rvfi_rs3_addr   <= q_rs3_addr[rd_idx];
                rvfi_rs1_rdata  <= q_rs1_rdata[rd_idx];
                rvfi_rs2_rdata  <= q_rs2_rdata[rd_idx];
                rvfi_rs3_rdata  <= q_rs3_rdata[rd_idx];
                rvfi_rd_addr    <= rd_addr_eff;
                rvfi_rd_wdata   <= rd_is_x0 ? '0 : ret_rd_wdata;
                rvfi_rd_wide    <= ret_rd_wide;
                rvfi_rd_wdatahi <= (rd_is_x0 || !ret_rd_wide) ? '0 : ret_rd_wdatahi;
            end
        end
    end

`ifdef XCFI_RVFI_MEM_TRACE_EN
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else if (pop) begin
            rvfi_mem_addr  <= ret_mem_addr;
            rvfi_mem_rmask <= ret_trap ? 4'd0 : ret_mem_rmask;
            rvfi_mem_wmask <= ret_trap ? 4'd0 : ret_mem_wmask;
            rvfi_mem_rdata <= ret_mem_rdata;
            rvfi_mem_wdata <= ret_mem_wdata;
        end
    end
`else
    logic unused_mem;
    assign unused_mem     = ^{ret_mem_addr, ret_mem_rmask, ret_mem_wmask, ret_mem_rdata, ret_mem_wdata};
    assign rvfi_mem_addr  = '0;
    assign rvfi_mem_rmask = '0;
    assign rvfi_mem_wmask = '0;
    assign rvfi_mem_rdata = '0;
    assign rvfi_mem_wdata = '0;
`endif

endmodule

// File: tb/tb_xcfi_rvfi_emitter.sv
// Directed bench for xcfi_rvfi_emitter: table-driven issue/retire pairs plus fill, flush and async-reset sequences.
module tb_xcfi_rvfi_emitter;

    localparam int XLEN = 32;

    logic            g_clk = 1'b0;
    logic            g_resetn;
    logic            iss_valid, iss_ready;
    logic [31:0]     iss_insn;
    logic [XLEN-1:0] iss_pc, iss_rs1_rdata, iss_rs2_rdata, iss_rs3_rdata;
    logic [4:0]      iss_rs1_addr, iss_rs2_addr, iss_rs3_addr;
    logic            ret_valid, ret_trap, ret_rd_wide, flush;
    logic [4:0]      ret_rd_addr;
    logic [XLEN-1:0] ret_rd_wdata, ret_rd_wdatahi, ret_pc_wdata;
    logic [XLEN-1:0] ret_mem_addr, ret_mem_rdata, ret_mem_wdata;
    logic [3:0]      ret_mem_rmask, ret_mem_wmask;
    logic            rvfi_valid, rvfi_trap, rvfi_rd_wide, err_underflow;
    logic [63:0]     rvfi_order;
    logic [31:0]     rvfi_insn;
    logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
    logic [XLEN-1:0] rvfi_rd_wdata, rvfi_rd_wdatahi;
    logic [XLEN-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]      rvfi_mem_rmask, rvfi_mem_wmask;

    int    checks = 0;
    int    errors = 0;
    longint unsigned exp_order = 0;

    always #5 g_clk = ~g_clk;

    xcfi_rvfi_emitter #(.XLEN(XLEN), .DEPTH(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_insn(iss_insn), .iss_pc(iss_pc),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr), .iss_rs3_addr(iss_rs3_addr),
        .iss_rs1_rdata(iss_rs1_rdata), .iss_rs2_rdata(iss_rs2_rdata), .iss_rs3_rdata(iss_rs3_rdata),
        .ret_valid(ret_valid), .ret_trap(ret_trap), .ret_rd_addr(ret_rd_addr),
        .ret_rd_wdata(ret_rd_wdata), .ret_rd_wdatahi(ret_rd_wdatahi), .ret_rd_wide(ret_rd_wide),
        .ret_pc_wdata(ret_pc_wdata), .ret_mem_addr(ret_mem_addr), .ret_mem_rmask(ret_mem_rmask),
        .ret_mem_wmask(ret_mem_wmask), .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata),
        .flush(flush), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_wide(rvfi_rd_wide),
        .rvfi_rd_wdatahi(rvfi_rd_wdatahi), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .err_underflow(err_underflow)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
        logic [4:0]  rs3_addr;
        logic [31:0] rs3_rdata;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] rd_wdatahi;
        logic        rd_wide;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [4:0]  exp_rd_addr;
        logic [31:0] exp_rd_wdata;
        logic [31:0] exp_rd_wdatahi;
        logic [3:0]  exp_rmask;
        logic [3:0]  exp_wmask;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_insn = 0; iss_pc = 0;
        iss_rs1_addr = 0; iss_rs2_addr = 0; iss_rs3_addr = 0;
        iss_rs1_rdata = 0; iss_rs2_rdata = 0; iss_rs3_rdata = 0;
        ret_valid = 0; ret_trap = 0; ret_rd_addr = 0; ret_rd_wdata = 0; ret_rd_wdatahi = 0;
        ret_rd_wide = 0; ret_pc_wdata = 0; ret_mem_addr = 0; ret_mem_rmask = 0; ret_mem_wmask = 0;
        ret_mem_rdata = 0; ret_mem_wdata = 0; flush = 0;
    endtask

    task automatic drive_issue(input logic [31:0] pc, input logic [31:0] insn);
        iss_valid = 1; iss_pc = pc; iss_insn = insn;
    endtask

    // Issue one instruction, retire it on the following cycle, then check the registered packet.
    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [31:0] e_addr, e_rdata, e_wdata;
        logic [3:0]  e_rmask, e_wmask;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge g_clk);
        idle_inputs();
        iss_valid = 1; iss_pc = v.pc; iss_insn = v.insn;
        iss_rs1_addr = v.rs1_addr; iss_rs1_rdata = v.rs1_rdata;
        iss_rs2_addr = v.rs2_addr; iss_rs2_rdata = v.rs2_rdata;
        iss_rs3_addr = v.rs3_addr; iss_rs3_rdata = v.rs3_rdata;
        @(negedge g_clk);
        idle_inputs();
        ret_valid = 1; ret_trap = v.trap; ret_rd_addr = v.rd_addr; ret_rd_wdata = v.rd_wdata;
        ret_rd_wdatahi = v.rd_wdatahi; ret_rd_wide = v.rd_wide; ret_pc_wdata = v.pc_wdata;
        ret_mem_addr = v.mem_addr; ret_mem_rmask = v.mem_rmask; ret_mem_wmask = v.mem_wmask;
        ret_mem_rdata = v.mem_rdata; ret_mem_wdata = v.mem_wdata;
        @(negedge g_clk);
        idle_inputs();
`ifdef XCFI_RVFI_MEM_TRACE_EN
        e_addr = v.mem_addr; e_rdata = v.mem_rdata; e_wdata = v.mem_wdata;
        e_rmask = v.exp_rmask; e_wmask = v.exp_wmask;
`else
        e_addr = 0; e_rdata = 0; e_wdata = 0; e_rmask = 0; e_wmask = 0;
`endif
        check_output({tag, " valid"}, 64'(rvfi_valid), 64'd1);
        check_output({tag, " order"}, rvfi_order, exp_order);
        check_output({tag, " insn"}, 64'(rvfi_insn), 64'(v.insn));
        check_output({tag, " pc_rdata"}, 64'(rvfi_pc_rdata), 64'(v.pc));
        check_output({tag, " pc_wdata"}, 64'(rvfi_pc_wdata), 64'(v.pc_wdata));
        check_output({tag, " rs1_addr"}, 64'(rvfi_rs1_addr), 64'(v.rs1_addr));
        check_output({tag, " rs1_rdata"}, 64'(rvfi_rs1_rdata), 64'(v.rs1_rdata));
        check_output({tag, " rs2_addr"}, 64'(rvfi_rs2_addr), 64'(v.rs2_addr));
        check_output({tag, " rs2_rdata"}, 64'(rvfi_rs2_rdata), 64'(v.rs2_rdata));
        check_output({tag, " rs3_addr"}, 64'(rvfi_rs3_addr), 64'(v.rs3_addr));
        check_output({tag, " rs3_rdata"}, 64'(rvfi_rs3_rdata), 64'(v.rs3_rdata));
        check_output({tag, " trap"}, 64'(rvfi_trap), 64'(v.trap));
        check_output({tag, " rd_addr"}, 64'(rvfi_rd_addr), 64'(v.exp_rd_addr));
        check_output({tag, " rd_wdata"}, 64'(rvfi_rd_wdata), 64'(v.exp_rd_wdata));
        check_output({tag, " rd_wdatahi"}, 64'(rvfi_rd_wdatahi), 64'(v.exp_rd_wdatahi));
        check_output({tag, " mem_addr"}, 64'(rvfi_mem_addr), 64'(e_addr));
        check_output({tag, " mem_rmask"}, 64'(rvfi_mem_rmask), 64'(e_rmask));
        check_output({tag, " mem_wmask"}, 64'(rvfi_mem_wmask), 64'(e_wmask));
        check_output({tag, " mem_rdata"}, 64'(rvfi_mem_rdata), 64'(e_rdata));
        check_output({tag, " mem_wdata"}, 64'(rvfi_mem_wdata), 64'(e_wdata));
        exp_order++;
        @(negedge g_clk);
        check_output({tag, " valid pulse ends"}, 64'(rvfi_valid), 64'd0);
        check_output({tag, " data held"}, 64'(rvfi_pc_rdata), 64'(v.pc));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{default: 0, pc: 32'h100, insn: 32'h0A20_A0AB, rs1_addr: 5'd1, rs1_rdata: 32'h1234_5678,
                    rs2_addr: 5'd2, rd_addr: 5'd5, rd_wdata: 32'h2468_ACF0, pc_wdata: 32'h104,
                    exp_rd_addr: 5'd5, exp_rd_wdata: 32'h2468_ACF0};
        vecs[1] = '{default: 0, pc: 32'h104, insn: 32'h0000_0013, rs1_addr: 5'd3, rs1_rdata: 32'hAAAA_5555,
                    rs2_addr: 5'd4, rs2_rdata: 32'h0F0F_0F0F, rs3_addr: 5'd7, rs3_rdata: 32'hCAFE_F00D,
                    rd_addr: 5'd0, rd_wdata: 32'hFFFF_FFFF, rd_wdatahi: 32'h1234_5678, rd_wide: 1'b1,
                    pc_wdata: 32'h108, mem_addr: 32'h1000, mem_rmask: 4'hF, mem_rdata: 32'h1111_2222,
                    exp_rmask: 4'hF};
        vecs[2] = '{default: 0, pc: 32'h108, insn: 32'h0062_A023, rs1_addr: 5'd8, rs1_rdata: 32'h0000_2000,
                    rd_addr: 5'd6, rd_wdata: 32'h0123_4567, rd_wdatahi: 32'hDEAD_BEEF, rd_wide: 1'b1,
                    pc_wdata: 32'h10C, mem_addr: 32'h2004, mem_wmask: 4'h3, mem_wdata: 32'h0000_BEEF,
                    exp_rd_addr: 5'd6, exp_rd_wdata: 32'h0123_4567, exp_rd_wdatahi: 32'hDEAD_BEEF,
                    exp_wmask: 4'h3};
        vecs[3] = '{default: 0, pc: 32'h10C, insn: 32'h0010_0393, rd_addr: 5'd7, rd_wdata: 32'h89AB_CDEF,
                    rd_wdatahi: 32'h1111_1111, rd_wide: 1'b0, pc_wdata: 32'h110,
                    exp_rd_addr: 5'd7, exp_rd_wdata: 32'h89AB_CDEF};
        vecs[4] = '{default: 0, pc: 32'h110, insn: 32'h0000_0073, trap: 1'b1, rd_addr: 5'd3,
                    rd_wdata: 32'h0000_0055, pc_wdata: 32'h8000_0000, mem_addr: 32'h3000,
                    mem_wmask: 4'hF, mem_wdata: 32'h7777_7777};
        vecs[5] = '{default: 0, pc: 32'h114, insn: 32'h01F0_0F8B, rs3_addr: 5'd30, rs3_rdata: 32'h5A5A_5A5A,
                    rd_addr: 5'd31, rd_wdata: 32'hFFFF_FFFE, rd_wdatahi: 32'h8000_0001, rd_wide: 1'b1,
                    pc_wdata: 32'h118, exp_rd_addr: 5'd31, exp_rd_wdata: 32'hFFFF_FFFE,
                    exp_rd_wdatahi: 32'h8000_0001};

        idle_inputs();
        g_resetn = 0;
        repeat (2) @(negedge g_clk);
        g_resetn = 1;
        @(negedge g_clk);
        check_output("reset valid", 64'(rvfi_valid), 64'd0);
        check_output("reset order", rvfi_order, 64'd0);
        check_output("reset iss_ready", 64'(iss_ready), 64'd1);
        check_output("reset err_underflow", 64'(err_underflow), 64'd0);
        check_output("reset pc_rdata", 64'(rvfi_pc_rdata), 64'd0);
        check_output("reset insn", 64'(rvfi_insn), 64'd0);

        for (int i = 0; i < 6; i++)
            apply_stimulus(vecs[i], i);

        // Fill to full, then issue and retire together; packets must come out in issue order.
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            idle_inputs();
            drive_issue(32'h200 + 32'(4 * i), 32'h0000_0013);
        end
        @(negedge g_clk);
        idle_inputs();
        check_output("fill full iss_ready", 64'(iss_ready), 64'd0);
        drive_issue(32'h210, 32'h0000_0013);
        ret_valid = 1;
        #1;
        check_output("fill issue+retire iss_ready", 64'(iss_ready), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge g_clk);
            iss_valid = 0;
            if (k == 5) ret_valid = 0;
            check_output($sformatf("fill pkt%0d valid", k), 64'(rvfi_valid), 64'd1);
            check_output($sformatf("fill pkt%0d pc", k), 64'(rvfi_pc_rdata), 64'(32'h200 + 32'(4 * (k - 1))));
            check_output($sformatf("fill pkt%0d order", k), rvfi_order, exp_order);
            exp_order++;
        end
        @(negedge g_clk);
        check_output("fill drained valid", 64'(rvfi_valid), 64'd0);
        check_output("fill drained err_underflow", 64'(err_underflow), 64'd0);

        // Flush with a simultaneous retire and issue: one packet, the issue is dropped.
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            idle_inputs();
            drive_issue(32'h300 + 32'(4 * i), 32'h0000_0033);
        end
        @(negedge g_clk);
        idle_inputs();
        drive_issue(32'h30C, 32'h0000_0033);
        ret_valid = 1;
        flush = 1;
        @(negedge g_clk);
        idle_inputs();
        check_output("flush pkt valid", 64'(rvfi_valid), 64'd1);
        check_output("flush pkt pc", 64'(rvfi_pc_rdata), 64'h300);
        check_output("flush pkt order", rvfi_order, exp_order);
        exp_order++;
        @(negedge g_clk);
        check_output("flush single pulse", 64'(rvfi_valid), 64'd0);
        ret_valid = 1;
        @(negedge g_clk);
        idle_inputs();
        check_output("underflow flag", 64'(err_underflow), 64'd1);
        check_output("underflow no packet", 64'(rvfi_valid), 64'd0);
        check_output("underflow order held", rvfi_order, exp_order - 1);
        @(negedge g_clk);
        check_output("underflow sticky", 64'(err_underflow), 64'd1);

        // Async reset while a packet is being presented.
        @(negedge g_clk);
        drive_issue(32'h400, 32'h0000_0013);
        @(negedge g_clk);
        idle_inputs();
        ret_valid = 1;
        ret_rd_addr = 5'd9;
        ret_rd_wdata = 32'h0BAD_F00D;
        @(negedge g_clk);
        idle_inputs();
        check_output("pre-reset valid", 64'(rvfi_valid), 64'd1);
        #2;
        g_resetn = 0;
        #1;
        check_output("async reset valid", 64'(rvfi_valid), 64'd0);
        check_output("async reset order", rvfi_order, 64'd0);
        check_output("async reset pc_rdata", 64'(rvfi_pc_rdata), 64'd0);
        check_output("async reset rd_wdata", 64'(rvfi_rd_wdata), 64'd0);
        check_output("async reset err_underflow", 64'(err_underflow), 64'd0);
        check_output("async reset iss_ready", 64'(iss_ready), 64'd1);
        @(negedge g_clk);
        g_resetn = 1;
        exp_order = 0;
        apply_stimulus(vecs[2], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
